// File: rtl/versat_generator_n_if.sv
// Beat handshake bundle of the Versat N-level generator.
// The master drives the beat and completion flag, the slave drives ready.
interface versat_generator_n_if #(
   parameter int ADDR_W = 32
);
   logic              valid_o;
   logic              ready_i;
   logic [ADDR_W-1:0] addr_o;
   logic              done_o;

   modport master (
      output valid_o,
      output addr_o,
      output done_o,
      input  ready_i
   );

   modport slave (
      input  valid_o,
      input  addr_o,
      input  done_o,
      output ready_i
   );
endinterface

// File: rtl/versat_generator_n.sv
// Versat N-level address/value generator: nested loops with duty gating,
// valid/ready stall, sticky done and start delay.
module versat_generator_n #(
   parameter int NUM_LEVELS = 4,
   parameter int ADDR_W     = 32,
   parameter int PERIOD_W   = 16,
   parameter int ITER_W     = 32,
   parameter int DELAY_W    = 7
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             running,
   input  logic                             run,
   input  logic [ADDR_W-1:0]                start,
   input  logic [PERIOD_W-1:0]              period,
   input  logic [PERIOD_W-1:0]              duty,
   input  logic [NUM_LEVELS*ADDR_W-1:0]     incr,
   input  logic [(NUM_LEVELS-1)*ITER_W-1:0] iterations,
   input  logic [DELAY_W-1:0]               delay,
   versat_generator_n_if.master             bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_GEN,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_duty;
   logic [PERIOD_W-1:0] r_cnt0;
   logic [ADDR_W-1:0]   r_incr [NUM_LEVELS];
   logic [ADDR_W-1:0]   r_val  [NUM_LEVELS];
   logic [ITER_W-1:0]   r_iter [1:NUM_LEVELS-1];
   logic [ITER_W-1:0]   r_cnt  [1:NUM_LEVELS-1];
   logic [DELAY_W-1:0]  r_dcnt;
   logic                r_zero;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_valid;
   logic                r_done;

   logic                w_carry [NUM_LEVELS];
   logic [ADDR_W-1:0]   w_nval  [NUM_LEVELS];
   logic [ITER_W-1:0]   w_ncnt  [1:NUM_LEVELS-1];
   logic [PERIOD_W-1:0] w_ncnt0;
   logic [PERIOD_W-1:0] w_duty;
   logic                w_zero;
   logic                w_last;
   logic                w_nvalid;
   logic                w_stall;

   // r_val[k] holds the value with all indices below k at zero
   always_comb begin
      w_carry[0] = (r_cnt0 == r_period - PERIOD_W'(1));
      for (int k = 1; k < NUM_LEVELS; k++) begin
         w_carry[k] = w_carry[k-1] &&
                      (r_cnt[k] == r_iter[k] - ITER_W'(1));
      end
      w_ncnt0 = w_carry[0] ? '0 : r_cnt0 + PERIOD_W'(1);
      for (int k = 1; k < NUM_LEVELS; k++) begin
         if (w_carry[k])
            w_ncnt[k] = '0;
         else if (w_carry[k-1])
            w_ncnt[k] = r_cnt[k] + ITER_W'(1);
         else
            w_ncnt[k] = r_cnt[k];
      end
      w_nval[NUM_LEVELS-1] = w_carry[NUM_LEVELS-2] ?
         r_val[NUM_LEVELS-1] + r_incr[NUM_LEVELS-1] :
         r_val[NUM_LEVELS-1];
      for (int k = NUM_LEVELS - 2; k >= 1; k--) begin
         if (w_carry[k])
            w_nval[k] = w_nval[k+1];
         else if (w_carry[k-1])
            w_nval[k] = r_val[k] + r_incr[k];
         else
            w_nval[k] = r_val[k];
      end
      w_nval[0] = w_carry[0] ? w_nval[1] : r_val[0] + r_incr[0];
      w_last    = w_carry[NUM_LEVELS-1];
      w_nvalid  = (w_ncnt0 < r_duty);
      w_stall   = r_valid && !bus.ready_i;
   end

   always_comb begin
      w_duty = (duty > period) ? period : duty;
      w_zero = (period == '0);
      for (int k = 1; k < NUM_LEVELS; k++) begin
         if (iterations[(k-1)*ITER_W +: ITER_W] == '0)
            w_zero = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_period <= '0;
         r_duty   <= '0;
         r_cnt0   <= '0;
         r_dcnt   <= '0;
         r_zero   <= 1'b0;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         for (int k = 0; k < NUM_LEVELS; k++) begin
            r_incr[k] <= '0;
            r_val[k]  <= '0;
         end
         for (int k = 1; k < NUM_LEVELS; k++) begin
            r_iter[k] <= '0;
            r_cnt[k]  <= '0;
         end
      end else if (!running) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
      end else if (run) begin
         r_period <= period;
         r_duty   <= w_duty;
         r_zero   <= w_zero;
         r_cnt0   <= '0;
         r_dcnt   <= delay - DELAY_W'(1);
         r_done   <= 1'b0;
         for (int k = 0; k < NUM_LEVELS; k++) begin
            r_incr[k] <= incr[k*ADDR_W +: ADDR_W];
            r_val[k]  <= start;
         end
         for (int k = 1; k < NUM_LEVELS; k++) begin
            r_iter[k] <= iterations[(k-1)*ITER_W +: ITER_W];
            r_cnt[k]  <= '0;
         end
         if (delay != '0) begin
            r_state <= S_DELAY;
            r_valid <= 1'b0;
         end else if (w_zero) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
         end else begin
            r_state <= S_GEN;
            r_addr  <= start;
            r_valid <= (w_duty != '0);
         end
      end else begin
         unique case (r_state)
            S_DELAY: begin
               if (r_dcnt != '0) begin
                  r_dcnt <= r_dcnt - DELAY_W'(1);
               end else if (r_zero) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_GEN;
                  r_addr  <= r_val[0];
                  r_valid <= (r_duty != '0);
               end
            end
            S_GEN: begin
               if (!w_stall) begin
                  if (w_last) begin
                     r_state <= S_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt0  <= w_ncnt0;
                     r_cnt   <= w_ncnt;
                     r_val   <= w_nval;
                     r_addr  <= w_nval[0];
                     r_valid <= w_nvalid;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.valid_o = r_valid;
   assign bus.addr_o  = r_addr;
   assign bus.done_o  = r_done;

endmodule

// File: tb/tb_versat_generator_n.sv
// Directed bench for versat_generator_n: a 2-level and a 4-level
// 8-bit instance driven through basic, gap, stall, abort and wrap cases.
module tb_versat_generator_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        running = 1'b1;

   logic        run2 = 1'b0;
   logic [31:0] start2 = '0;
   logic [15:0] period2 = '0;
   logic [15:0] duty2 = '0;
   logic [63:0] incr2 = '0;
   logic [31:0] iter2 = '0;
   logic [6:0]  delay2 = '0;

   logic        run4 = 1'b0;
   logic [7:0]  start4 = '0;
   logic [15:0] period4 = '0;
   logic [15:0] duty4 = '0;
   logic [31:0] incr4 = '0;
   logic [95:0] iter4 = '0;
   logic [6:0]  delay4 = '0;

   int n_cmp = 0;
   int n_err = 0;

   versat_generator_n_if #(.ADDR_W(32)) bus2 ();
   versat_generator_n_if #(.ADDR_W(8))  bus4 ();

   versat_generator_n #(
      .NUM_LEVELS(2), .ADDR_W(32)
   ) dut2 (
      .clk(clk), .rst(rst), .running(running), .run(run2),
      .start(start2), .period(period2), .duty(duty2),
      .incr(incr2), .iterations(iter2), .delay(delay2),
      .bus(bus2)
   );

   versat_generator_n #(
      .NUM_LEVELS(4), .ADDR_W(8)
   ) dut4 (
      .clk(clk), .rst(rst), .running(running), .run(run4),
      .start(start4), .period(period4), .duty(duty4),
      .incr(incr4), .iterations(iter4), .delay(delay4),
      .bus(bus4)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic basic_cfg;
      start2  = 32'd100;
      period2 = 16'd3;
      duty2   = 16'd3;
      incr2   = {32'd10, 32'd1};
      iter2   = 32'd2;
      delay2  = 7'd0;
   endtask

   task automatic fire2;
      run2 = 1'b1;
      tick();
      run2 = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_a [8];
      logic        exp_v [8];
      logic [7:0]  m;

      bus2.ready_i = 1'b1;
      bus4.ready_i = 1'b1;

      tick();
      tick();
      chk("rst_valid2", bus2.valid_o, 0);
      chk("rst_addr2",  bus2.addr_o,  0);
      chk("rst_done2",  bus2.done_o,  0);
      chk("rst_valid4", bus4.valid_o, 0);
      chk("rst_addr4",  bus4.addr_o,  0);
      chk("rst_done4",  bus4.done_o,  0);
      rst = 1'b0;
      tick();

      // basic nest
      basic_cfg();
      exp_a = '{100, 101, 102, 110, 111, 112, 0, 0};
      fire2();
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("basic_v%0d", i), bus2.valid_o, 1);
         chk($sformatf("basic_a%0d", i), bus2.addr_o, exp_a[i]);
         tick();
      end
      chk("basic_done",  bus2.done_o,  1);
      chk("basic_vdone", bus2.valid_o, 0);

      // duty gap
      period2 = 16'd4;
      duty2   = 16'd2;
      exp_v = '{1, 1, 0, 0, 1, 1, 0, 0};
      exp_a = '{100, 101, 0, 0, 110, 111, 0, 0};
      fire2();
      chk("gap_done_clr", bus2.done_o, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("gap_v%0d", i), bus2.valid_o, 32'(exp_v[i]));
         if (exp_v[i])
            chk($sformatf("gap_a%0d", i), bus2.addr_o, exp_a[i]);
         tick();
      end
      chk("gap_done", bus2.done_o, 1);

      // duty above period clamps
      duty2 = 16'd9;
      exp_a = '{100, 101, 102, 103, 110, 111, 112, 113};
      fire2();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("clamp_v%0d", i), bus2.valid_o, 1);
         chk($sformatf("clamp_a%0d", i), bus2.addr_o, exp_a[i]);
         tick();
      end
      chk("clamp_done", bus2.done_o, 1);

      // backpressure on 101 for two cycles
      basic_cfg();
      fire2();
      chk("bp_a100", bus2.addr_o, 100);
      tick();
      bus2.ready_i = 1'b0;
      chk("bp_a101_0", bus2.addr_o, 101);
      tick();
      chk("bp_a101_1", bus2.addr_o, 101);
      chk("bp_v101_1", bus2.valid_o, 1);
      tick();
      bus2.ready_i = 1'b1;
      chk("bp_a101_2", bus2.addr_o, 101);
      tick();
      chk("bp_a102", bus2.addr_o, 102);
      tick();
      chk("bp_a110", bus2.addr_o, 110);
      tick();
      chk("bp_a111", bus2.addr_o, 111);
      tick();
      chk("bp_a112", bus2.addr_o, 112);
      chk("bp_ndone", bus2.done_o, 0);
      tick();
      chk("bp_done", bus2.done_o, 1);

      // start delay of 5 cycles
      delay2 = 7'd5;
      fire2();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("dly_v%0d", i), bus2.valid_o, 0);
         tick();
      end
      chk("dly_first_v", bus2.valid_o, 1);
      chk("dly_first_a", bus2.addr_o, 100);
      chk("dly_ndone",   bus2.done_o, 0);

      // zero iteration count completes at once
      iter2  = 32'd0;
      delay2 = 7'd0;
      fire2();
      chk("zero_done", bus2.done_o, 1);
      chk("zero_v",    bus2.valid_o, 0);
      tick();
      chk("zero_v2",   bus2.valid_o, 0);

      // running drop mid-sequence
      basic_cfg();
      fire2();
      tick();
      tick();
      chk("abort_pre_a", bus2.addr_o, 102);
      running = 1'b0;
      tick();
      chk("abort_v",    bus2.valid_o, 0);
      chk("abort_done", bus2.done_o, 0);
      running = 1'b1;
      tick();
      chk("abort_idle_v", bus2.valid_o, 0);

      // run mid-sequence restarts from new start
      fire2();
      tick();
      chk("rs_pre_a", bus2.addr_o, 101);
      start2 = 32'd200;
      fire2();
      chk("rs_v", bus2.valid_o, 1);
      chk("rs_a", bus2.addr_o, 200);
      tick();
      chk("rs_a2", bus2.addr_o, 201);

      // asynchronous reset mid-sequence
      #2;
      rst = 1'b1;
      #1;
      chk("arst_v",    bus2.valid_o, 0);
      chk("arst_a",    bus2.addr_o,  0);
      chk("arst_done", bus2.done_o,  0);
      #1;
      rst = 1'b0;
      tick();

      // 4 levels, 8-bit wrap
      start4  = 8'd250;
      period4 = 16'd2;
      duty4   = 16'd2;
      incr4   = {8'd11, 8'd7, 8'd5, 8'd3};
      iter4   = {32'd2, 32'd2, 32'd2};
      run4 = 1'b1;
      tick();
      run4 = 1'b0;
      for (int i3 = 0; i3 < 2; i3++)
         for (int i2 = 0; i2 < 2; i2++)
            for (int i1 = 0; i1 < 2; i1++)
               for (int i0 = 0; i0 < 2; i0++) begin
                  m = 8'(250 + i0*3 + i1*5 + i2*7 + i3*11);
                  chk($sformatf("wrap_v%0d%0d%0d%0d", i3, i2, i1, i0),
                      bus4.valid_o, 1);
                  chk($sformatf("wrap_a%0d%0d%0d%0d", i3, i2, i1, i0),
                      bus4.addr_o, 32'(m));
                  tick();
               end
      chk("wrap_done", bus4.done_o, 1);
      chk("wrap_vend", bus4.valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
